br_resolve: RTL and testbench

- Resolves conditional branches and jumps from the comparator flags (less/equal) and instruction funct3.
- Produces the comparator's unsigned-select, the taken decision, and a registered mispredict pulse.
- Keeps a 2-bit saturating branch-history table (BHT) that the fetch stage reads for prediction.
- Keeps saturating performance counters for branches, taken branches and mispredicts.
- Sits between the branch comparator and PC-select/fetch logic.

---
 rtl/br_resolve_if.sv | 43 ++++
 rtl/br_resolve.sv | 118 +++++++++++
 tb/tb_br_resolve.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/br_resolve_if.sv
// Branch-resolve bus: resolving-instruction inputs, fetch lookup PC,
// and the resolve results, counters and prediction returned to the pipeline.
//
// Handshake: there is no backpressure. i_valid qualifies the resolving
// instruction for exactly the cycle it is high; the block always accepts it.
// o_br_un and o_pred_taken are driven every cycle regardless of i_valid.
interface br_resolve_if #(
    parameter int CNT_W = 32
);
    logic             i_valid;
    logic [31:0]      i_pc;
    logic             i_is_br;
    logic             i_is_jmp;
    logic [2:0]       i_funct3;
    logic             i_br_less;
    logic             i_br_equal;
    logic             i_pred_taken;
    logic [31:0]      i_pred_pc;
    logic             o_br_un;
    logic             o_pred_taken;
    logic             o_taken;
    logic             o_mispredict;
    logic             o_illegal;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_taken_cnt;
    logic [CNT_W-1:0] o_mispred_cnt;

    // Pipeline side: supplies the instruction, consumes results.
    modport master (
        output i_valid, i_pc, i_is_br, i_is_jmp, i_funct3,
        output i_br_less, i_br_equal, i_pred_taken, i_pred_pc,
        input  o_br_un, o_pred_taken, o_taken, o_mispredict, o_illegal,
        input  o_br_cnt, o_taken_cnt, o_mispred_cnt
    );

    // Resolver side.
    modport slave (
        input  i_valid, i_pc, i_is_br, i_is_jmp, i_funct3,
        input  i_br_less, i_br_equal, i_pred_taken, i_pred_pc,
        output o_br_un, o_pred_taken, o_taken, o_mispredict, o_illegal,
        output o_br_cnt, o_taken_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/br_resolve.sv
// Branch resolver: evaluates branch/jump outcome from comparator flags,
// flags mispredicts and illegal funct3, trains a 2-bit BHT and keeps
// saturating performance counters.
module br_resolve #(
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input logic         i_clk,
    input logic         i_rst_n,
    br_resolve_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] look_idx;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;
    logic             cond;
    logic             legal;
    logic             taken;
    logic             br_upd;
    logic             illegal_ev;
    logic             mispred_ev;
    logic             mispred_q;
    logic             illegal_q;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic             lint_unused;

    // Only the word-index bits of the PCs address the BHT.
    assign lint_unused = ^{bus.i_pc[31:IDX_W+2], bus.i_pc[1:0],
                           bus.i_pred_pc[31:IDX_W+2], bus.i_pred_pc[1:0]};

    assign upd_idx  = bus.i_pc[IDX_W+1:2];
    assign look_idx = bus.i_pred_pc[IDX_W+1:2];

    // Branch condition selected by funct3; illegal encodings never take.
    always_comb begin
        cond = 1'b0;
        case (bus.i_funct3)
            3'b000:         cond = bus.i_br_equal;
            3'b001:         cond = ~bus.i_br_equal;
            3'b100, 3'b110: cond = bus.i_br_less;
            3'b101, 3'b111: cond = ~bus.i_br_less;
            default:        cond = 1'b0;
        endcase
    end

    assign legal      = (bus.i_funct3[2:1] != 2'b01);
    assign taken      = bus.i_valid & (bus.i_is_jmp | (bus.i_is_br & cond));
    // A jump flagged as a branch as well is handled purely as a jump.
    assign br_upd     = bus.i_valid & bus.i_is_br & ~bus.i_is_jmp & legal;
    assign illegal_ev = bus.i_valid & bus.i_is_br & ~bus.i_is_jmp & ~legal;
    assign mispred_ev = bus.i_valid & (bus.i_is_br | bus.i_is_jmp) &
                        (taken != bus.i_pred_taken);

    assign bus.o_br_un      = (bus.i_funct3[2:1] == 2'b11);
    assign bus.o_taken      = taken;
    // Lookup reads registered state, so a same-cycle update shows next cycle.
    assign bus.o_pred_taken = bht_q[look_idx][1];
    assign bus.o_mispredict = mispred_q;
    assign bus.o_illegal    = illegal_q;
    assign bus.o_br_cnt     = br_cnt_q;
    assign bus.o_taken_cnt  = taken_cnt_q;
    assign bus.o_mispred_cnt = mispred_cnt_q;

    // Saturating 2-bit counter step for the entry being trained.
    always_comb begin
        ctr_cur = bht_q[upd_idx];
        ctr_d   = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
        end
    end

    // Saturating performance counter next-state.
    always_comb begin
        br_cnt_d      = br_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (br_upd && (br_cnt_q != '1))
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (br_upd && taken && (taken_cnt_q != '1))
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        if (mispred_ev && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end

    // BHT storage: reset to weak not-taken, trained by legal branches only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (br_upd) begin
            bht_q[upd_idx] <= ctr_d;
        end
    end

    // Event pulses and counters, one cycle behind the resolving instruction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mispred_q     <= 1'b0;
            illegal_q     <= 1'b0;
            br_cnt_q      <= '0;
            taken_cnt_q   <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mispred_q     <= mispred_ev;
            illegal_q     <= illegal_ev;
            br_cnt_q      <= br_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
endmodule

// File: tb/tb_br_resolve.sv
// Bench for br_resolve: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_br_resolve;
    localparam int CW   = 4;
    localparam int NENT = 16;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    br_resolve_if #(.CNT_W(CW)) bus ();

    br_resolve #(.BHT_ENTRIES(NENT), .CNT_W(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int bht_m [NENT];
    int m_br, m_tk, m_mp;
    bit m_misp, m_ill;

    function automatic int pc_entry(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic bit f3_legal(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    function automatic bit f3_cond(input logic [2:0] f3, input logic lt, input logic eq);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return lt;
            3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_taken();
        if (!bus.i_valid) return 1'b0;
        if (bus.i_is_jmp) return 1'b1;
        return bus.i_is_br && f3_legal(bus.i_funct3) &&
               f3_cond(bus.i_funct3, bus.i_br_less, bus.i_br_equal);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) bht_m[i] = 1;
            m_br = 0; m_tk = 0; m_mp = 0; m_misp = 0; m_ill = 0;
        end else begin
            bit tk, is_branch, ev_mp;
            tk        = m_taken();
            is_branch = bus.i_valid && bus.i_is_br && !bus.i_is_jmp;
            ev_mp     = bus.i_valid && (bus.i_is_br || bus.i_is_jmp) &&
                        (tk != bus.i_pred_taken);
            m_misp = ev_mp;
            m_ill  = is_branch && !f3_legal(bus.i_funct3);
            if (ev_mp && m_mp < CMAX) m_mp++;
            if (is_branch && f3_legal(bus.i_funct3)) begin
                int e;
                e = pc_entry(bus.i_pc);
                if (tk) begin
                    if (bht_m[e] < 3) bht_m[e]++;
                end else begin
                    if (bht_m[e] > 0) bht_m[e]--;
                end
                if (m_br < CMAX) m_br++;
                if (tk && m_tk < CMAX) m_tk++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare every output against the model each cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("br_un", 32'(bus.o_br_un), 32'(bus.i_funct3 == 3'd6 || bus.i_funct3 == 3'd7));
            check("taken", 32'(bus.o_taken), 32'(m_taken()));
            check("pred_taken", 32'(bus.o_pred_taken), 32'(bht_m[pc_entry(bus.i_pred_pc)] >= 2));
            check("mispredict", 32'(bus.o_mispredict), 32'(m_misp));
            check("illegal", 32'(bus.o_illegal), 32'(m_ill));
            check("br_cnt", 32'(bus.o_br_cnt), 32'(m_br));
            check("taken_cnt", 32'(bus.o_taken_cnt), 32'(m_tk));
            check("mispred_cnt", 32'(bus.o_mispred_cnt), 32'(m_mp));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [31:0] pc, input bit br, input bit jmp,
                         input logic [2:0] f3, input bit lt, input bit eq, input bit pt,
                         input logic [31:0] ppc);
        @(posedge clk);
        #1;
        bus.i_valid      = v;
        bus.i_pc         = pc;
        bus.i_is_br      = br;
        bus.i_is_jmp     = jmp;
        bus.i_funct3     = f3;
        bus.i_br_less    = lt;
        bus.i_br_equal   = eq;
        bus.i_pred_taken = pt;
        bus.i_pred_pc    = ppc;
    endtask

    task automatic idle(input logic [31:0] ppc);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ppc);
    endtask

    task automatic rand_step();
        drive(($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.i_valid = 0; bus.i_pc = 0; bus.i_is_br = 0; bus.i_is_jmp = 0;
        bus.i_funct3 = 0; bus.i_br_less = 0; bus.i_br_equal = 0;
        bus.i_pred_taken = 0; bus.i_pred_pc = 0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_mispredict", 32'(bus.o_mispredict), 0);
        check("rst_br_cnt", 32'(bus.o_br_cnt), 0);
        check("rst_pred", 32'(bus.o_pred_taken), 0);
        #1 rst_n = 1'b1;

        // BEQ taken, predicted not-taken.
        drive(1, 32'h40, 1, 0, 3'd0, 0, 1, 0, 32'h40);
        @(negedge clk);
        check("t1_taken", 32'(bus.o_taken), 1);
        check("t1_pred_before", 32'(bus.o_pred_taken), 0);
        idle(32'h40);
        @(negedge clk);
        check("t1_mispredict", 32'(bus.o_mispredict), 1);
        check("t1_br_cnt", 32'(bus.o_br_cnt), 1);
        check("t1_taken_cnt", 32'(bus.o_taken_cnt), 1);
        check("t1_mispred_cnt", 32'(bus.o_mispred_cnt), 1);
        check("t1_bht0", 32'(bus.o_pred_taken), 1);

        // Train entry 3 up with taken BLTs, then down with not-taken ones.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0C, 1, 0, 3'd4, 1, 0, 1, 32'h0C);
            @(negedge clk);
            check("t2_pred_up", 32'(bus.o_pred_taken), (i == 0) ? 0 : 1);
        end
        idle(32'h0C);
        @(negedge clk);
        check("t2_pred_sat", 32'(bus.o_pred_taken), 1);
        for (int i = 0; i < 4; i++) drive(1, 32'h0C, 1, 0, 3'd4, 0, 0, 0, 32'h0C);
        drive(1, 32'h0C, 1, 0, 3'd4, 1, 0, 0, 32'h0C);
        idle(32'h0C);
        @(negedge clk);
        check("t2_floor", 32'(bus.o_pred_taken), 0);
        check("t2_br_cnt", 32'(bus.o_br_cnt), 9);
        check("t2_taken_cnt", 32'(bus.o_taken_cnt), 5);

        // Unsigned select and condition decode.
        drive(1, 32'h100, 1, 0, 3'd6, 0, 0, 0, 32'h100);
        @(negedge clk);
        check("t3_un_110", 32'(bus.o_br_un), 1);
        drive(1, 32'h100, 1, 0, 3'd5, 0, 0, 0, 32'h100);
        @(negedge clk);
        check("t3_un_101", 32'(bus.o_br_un), 0);
        check("t3_bge", 32'(bus.o_taken), 1);
        drive(1, 32'h100, 1, 0, 3'd7, 1, 0, 0, 32'h100);
        @(negedge clk);
        check("t3_bgeu", 32'(bus.o_taken), 0);
        drive(1, 32'h100, 1, 0, 3'd1, 0, 0, 0, 32'h100);
        @(negedge clk);
        check("t3_bne", 32'(bus.o_taken), 1);

        // Illegal funct3 predicted taken.
        drive(1, 32'h20, 1, 0, 3'd3, 0, 1, 1, 32'h20);
        @(negedge clk);
        check("t4_taken", 32'(bus.o_taken), 0);
        idle(32'h20);
        @(negedge clk);
        check("t4_illegal", 32'(bus.o_illegal), 1);
        check("t4_mispredict", 32'(bus.o_mispredict), 1);
        check("t4_br_cnt", 32'(bus.o_br_cnt), 13);
        drive(1, 32'h20, 1, 0, 3'd0, 0, 1, 1, 32'h20);
        idle(32'h20);
        @(negedge clk);
        check("t4_bht_kept", 32'(bus.o_pred_taken), 1);

        // Same-cycle update and lookup of entry 4.
        drive(1, 32'h10, 1, 0, 3'd0, 0, 1, 1, 32'h10);
        @(negedge clk);
        check("t5_pred_same", 32'(bus.o_pred_taken), 0);
        idle(32'h10);
        @(negedge clk);
        check("t5_pred_next", 32'(bus.o_pred_taken), 1);

        // Saturate the mispredict counter with jumps predicted not-taken.
        for (int i = 0; i < 16; i++) drive(1, $urandom, 0, 1, 3'd0, 0, 0, 0, 32'h0);
        idle(32'h0);
        @(negedge clk);
        check("t6_mp_sat", 32'(bus.o_mispred_cnt), 32'hF);

        repeat (600) rand_step();

        // Asynchronous reset in the middle of a mispredicting jump.
        drive(1, 32'h0, 0, 1, 3'd0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        bus.i_valid = 1; bus.i_is_jmp = 1; bus.i_pred_taken = 0;
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_mispredict", 32'(bus.o_mispredict), 0);
        check("t7_rst_br_cnt", 32'(bus.o_br_cnt), 0);
        check("t7_rst_taken_cnt", 32'(bus.o_taken_cnt), 0);
        check("t7_rst_mp_cnt", 32'(bus.o_mispred_cnt), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NENT; i++) begin
            idle(32'(i * 4));
            @(negedge clk);
            check("t7_bht_reset", 32'(bus.o_pred_taken), 0);
        end

        repeat (300) rand_step();
        idle(32'h0);
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
